// File: rtl/mdu_sequencer.sv
// mdu_sequencer: radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Divide datapath present only when MDU_DIV_EN is defined.
// Ports: Clk, Rst_n (async low); Start/Op/A/B/Flush request side;
//   Busy, Stall, Done, DivByZero status; Hi, Lo result registers.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               sgn, sa, sb;
  logic               done_q, dbz_q;

  logic               op_ok, accept, go, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic               is_div, dz;
  logic [WIDTH:0]     r_sh, r_diff;
  logic [WIDTH-1:0]   quo, rem;
`endif

  // Signed ops work on magnitudes; -2^(W-1) maps to 2^(W-1) unsigned.
  assign mag_a = (~Op[0] & A[WIDTH-1]) ? -A : A;
  assign mag_b = (~Op[0] & B[WIDTH-1]) ? -B : B;

`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
  assign dz    = Op[1] & (B == '0);
  assign go    = accept & ~dz;
`else
  assign op_ok = ~Op[1];
  assign go    = accept;
`endif

  assign accept = Start & ~Flush & op_ok & (state == IDLE);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign Busy      = (state != IDLE);
  assign Stall     = Busy | accept;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (Flush)     state_d = IDLE;
        else if (last) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration. acc = {upper, lower}; lower holds the
  // multiplier / dividend, shifted out as iterations proceed.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, opb} : '0);
    step    = {mul_sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    r_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    r_diff = r_sh - {1'b0, opb};
    if (is_div) begin
      if (r_diff[WIDTH])
        step = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        step = {r_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    prod   = (sgn & (sa ^ sb)) ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    quo = (sgn & (sa ^ sb)) ? -acc[WIDTH-1:0]
                            : acc[WIDTH-1:0];
    rem = (sgn & sa) ? -acc[2*WIDTH-1:WIDTH]
                     : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      sgn    <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) dbz_q <= 1'b0;
      if (go) begin
        acc <= {{WIDTH{1'b0}}, mag_a};
        opb <= mag_b;
        sgn <= ~Op[0];
        sa  <= A[WIDTH-1];
        sb  <= B[WIDTH-1];
        cnt <= '0;
`ifdef MDU_DIV_EN
        is_div <= Op[1];
`endif
      end
      if (state == RUN) begin
        acc <= step;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FIX && !Flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
`ifdef MDU_DIV_EN
      // Divide by zero resolves without iterating.
      if (accept && dz) begin
        hi_q   <= A;
        lo_q   <= '1;
        dbz_q  <= 1'b1;
        done_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed scoreboard bench for mdu_sequencer.
// Divide cases run only when MDU_DIV_EN is defined.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n, Start, Flush;
  logic [1:0]   Op;
  logic [W-1:0] A, B;
  logic         Busy, Stall, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  res_t sb_q[$];
  res_t last;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total = 0;

  always #5 Clk = ~Clk;

  mdu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .A(A), .B(B), .Flush(Flush), .Busy(Busy),
    .Stall(Stall), .Done(Done), .DivByZero(DivByZero),
    .Hi(Hi), .Lo(Lo)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t r;
    logic signed [63:0] xa, xb, p, q, m;
    logic [63:0] u;
    xa = $signed(a);
    xb = $signed(b);
    r = '0;
    case (op)
      2'b00: begin
        p = xa * xb;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        r.hi = u[63:32];
        r.lo = u[31:0];
      end
      default: begin
        if (b == '0) begin
          r.hi = a;
          r.lo = '1;
          r.dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = xa / xb;
          m = xa % xb;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [1:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit push);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    #1;
    chk("stall_on_start", Stall, 1);
    if (push) sb_q.push_back(model(op, a, b));
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat = 0;
    bit busy_all = 1'b1;
    res_t e;
    while (!Done && lat < 40) begin
      if (!Busy) busy_all = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (exp_lat > 0) chk({tag, "_busy"}, busy_all, 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '0;
    last = e;
    chk({tag, "_hi"}, Hi, e.hi);
    chk({tag, "_lo"}, Lo, e.lo);
    chk({tag, "_dbz"}, DivByZero, e.dbz);
    chk({tag, "_stall"}, Stall, 0);
  endtask

  task automatic no_done(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      if (Done) seen = 1'b1;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    Rst_n = 1'b0;
    Start = 1'b0;
    Flush = 1'b0;
    Op = 2'b00;
    A = '0;
    B = '0;
    last = '0;
    tick();
    tick();
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_stall", Stall, 0);
    Rst_n = 1'b1;
    tick();

    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1);
    wait_done("mult_m3x7", 33);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done("multu_max", 33);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1);
    wait_done("mult_minsq", 33);
    issue(2'b00, 32'h8000_0000, 32'd1, 1);
    wait_done("mult_minx1", 33);
    issue(2'b01, 32'd0, 32'h1234_5678, 1);
    wait_done("multu_zero", 33);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(2'(i % 2), ra, rb, 1);
      wait_done("mult_rand", 33);
    end

    // Start while busy is dropped, not queued.
    issue(2'b00, 32'd2, 32'd3, 1);
    repeat (5) tick();
    Start = 1'b1;
    Op = 2'b01;
    A = 32'd100;
    B = 32'd100;
    repeat (3) tick();
    Start = 1'b0;
    wait_done("ignore_busy", 25);
    tick();
    tick();
    chk("ignore_noqueue", Busy, 0);

    // Flush mid-run leaves HI/LO alone.
    issue(2'b00, 32'd9, 32'd9, 0);
    repeat (19) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_idle", Busy, 0);
    no_done("flush_nodone", 40);
    chk("flush_hi", Hi, last.hi);
    chk("flush_lo", Lo, last.lo);

    // Flush and Start together in IDLE: request dropped.
    Start = 1'b1;
    Flush = 1'b1;
    Op = 2'b00;
    A = 32'd3;
    B = 32'd3;
    #1;
    chk("flushstart_stall", Stall, 0);
    tick();
    Start = 1'b0;
    Flush = 1'b0;
    chk("flushstart_busy", Busy, 0);
    no_done("flushstart_nodone", 3);

    // Asynchronous reset in the middle of a run.
    issue(2'b00, 32'd5, 32'd6, 0);
    repeat (9) tick();
    Rst_n = 1'b0;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_hi", Hi, 0);
    chk("midrst_lo", Lo, 0);
    tick();
    Rst_n = 1'b1;
    no_done("midrst_nodone", 36);
    last = '0;

`ifdef MDU_DIV_EN
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done("div_m7d2", 33);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("div_ovf", 33);
    issue(2'b11, 32'hFFFF_FFFF, 32'd1, 1);
    wait_done("divu_by1", 33);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1);
    wait_done("div_7dm2", 33);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'hFFFF);
      issue(2'(2 + i % 2), ra, rb, 1);
      wait_done("div_rand", 33);
    end
    issue(2'b11, 32'd5, 32'd0, 1);
    wait_done("divu_by0", 0);
    tick();
    chk("dbz_sticky", DivByZero, 1);
    chk("dbz_pulse", Done, 0);
    issue(2'b00, 32'd4, 32'd4, 1);
    chk("dbz_clear", DivByZero, 0);
    wait_done("mult_after_dbz", 33);
`else
    Start = 1'b1;
    Op = 2'b10;
    A = 32'd7;
    B = 32'd2;
    #1;
    chk("divoff_stall", Stall, 0);
    tick();
    Op = 2'b11;
    B = 32'd0;
    #1;
    chk("divoff_stall0", Stall, 0);
    tick();
    Start = 1'b0;
    chk("divoff_busy", Busy, 0);
    no_done("divoff_nodone", 5);
    chk("divoff_dbz", DivByZero, 0);
    chk("divoff_hi", Hi, last.hi);
    issue(2'b01, 32'd6, 32'd7, 1);
    wait_done("multu_after_div", 33);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
